rx_logic: RTL and testbench

//  Collects items from PORT_COUNT rx transceivers, each using a 2-phase req/ack

---
 rtl/rx_logic_if.sv | 33 +++
 rtl/rx_logic.sv | 110 +++++++++++
 tb/tb_rx_logic.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rx_logic_if.sv
// Router input-side bundle: rx transceiver 2-phase req/ack ports plus the fifo write port.
// rx_logic uses the master modport; transceivers/fifo (or a bench) use slave.
interface rx_logic_if #(
   parameter int unsigned SIZE       = 8,
   parameter int unsigned PORT_COUNT = 5
);

   logic                         fifo_write;
   logic                         fifo_full;
   logic [SIZE-1:0]              fifo_item_in;
   logic [PORT_COUNT-1:0]        fifo_push_req;
   logic [PORT_COUNT-1:0]        fifo_push_ack;
   logic [PORT_COUNT*SIZE-1:0]   fifo_push_data;

   modport master (
      output fifo_write,
      input  fifo_full,
      output fifo_item_in,
      input  fifo_push_req,
      output fifo_push_ack,
      input  fifo_push_data
   );

   modport slave (
      input  fifo_write,
      output fifo_full,
      input  fifo_item_in,
      output fifo_push_req,
      input  fifo_push_ack,
      output fifo_push_data
   );

endinterface

// File: rtl/rx_logic.sv
// Round-robin collector from PORT_COUNT 2-phase req/ack rx ports into the router input fifo.
// Define RX_LOGIC_SYNC_EN to pass each req bit through a 2-flop synchroniser.
module rx_logic #(
   parameter int          ID         = -1,
   parameter int unsigned SIZE       = 8,
   parameter int unsigned PORT_COUNT = 5,
   parameter int unsigned PTR_BITS   = 3
) (
   input logic        clk,
   input logic        reset,
   rx_logic_if.master bus
);

   if ((2 ** PTR_BITS) < PORT_COUNT) begin : g_ptr_check
      $error("rx_logic %0d: PTR_BITS too narrow for PORT_COUNT", ID);
   end

   logic [PORT_COUNT-1:0] req_eff;
   logic [PORT_COUNT-1:0] pending;
   logic [PORT_COUNT-1:0] ack_q, ack_d;
   logic [PORT_COUNT-1:0] sel_onehot;
   logic [PTR_BITS-1:0]   rr_q, rr_d;
   logic [PTR_BITS-1:0]   sel;
   logic [SIZE-1:0]       item_q, item_d;
   logic [SIZE-1:0]       sel_data;
   logic                  write_q, write_d;
   logic                  accept;

`ifdef RX_LOGIC_SYNC_EN
   logic [PORT_COUNT-1:0] req_s1_q, req_s2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         req_s1_q <= '0;
         req_s2_q <= '0;
      end else begin
         req_s1_q <= bus.fifo_push_req;
         req_s2_q <= req_s1_q;
      end
   end

   assign req_eff = req_s2_q;
`else
   assign req_eff = bus.fifo_push_req;
`endif

   assign pending = req_eff ^ ack_q;

   // Ports at or above rr_q beat ports below it; the second pass overrides the first.
   always_comb begin
      sel        = '0;
      sel_onehot = '0;
      for (int k = PORT_COUNT - 1; k >= 0; k--) begin
         if (pending[k] && (PTR_BITS'(k) < rr_q)) begin
            sel        = PTR_BITS'(k);
            sel_onehot = PORT_COUNT'(1) << k;
         end
      end
      for (int k = PORT_COUNT - 1; k >= 0; k--) begin
         if (pending[k] && (PTR_BITS'(k) >= rr_q)) begin
            sel        = PTR_BITS'(k);
            sel_onehot = PORT_COUNT'(1) << k;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < PORT_COUNT; k++) begin
         if (sel_onehot[k]) begin
            sel_data = bus.fifo_push_data[k*SIZE +: SIZE];
         end
      end
   end

   // Blocking on write_q keeps a just-filled fifo from being overrun.
   assign accept = (|pending) && !bus.fifo_full && !write_q;

   always_comb begin
      write_d = 1'b0;
      item_d  = item_q;
      ack_d   = ack_q;
      rr_d    = rr_q;
      if (accept) begin
         write_d = 1'b1;
         item_d  = sel_data;
         ack_d   = ack_q ^ sel_onehot;
         rr_d    = (sel == PTR_BITS'(PORT_COUNT - 1)) ? '0 : sel + PTR_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_q <= 1'b0;
         item_q  <= '0;
         ack_q   <= '0;
         rr_q    <= '0;
      end else begin
         write_q <= write_d;
         item_q  <= item_d;
         ack_q   <= ack_d;
         rr_q    <= rr_d;
      end
   end

   assign bus.fifo_write    = write_q;
   assign bus.fifo_item_in  = item_q;
   assign bus.fifo_push_ack = ack_q;

endmodule

// File: tb/tb_rx_logic.sv
// Scoreboard bench for rx_logic: pushes record expected (port, item) and a negedge monitor
// pops and compares on every fifo write.
module tb_rx_logic;

   localparam int unsigned SIZE       = 8;
   localparam int unsigned PORT_COUNT = 5;
   localparam int unsigned PTR_BITS   = 3;
`ifdef RX_LOGIC_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int unsigned     port;
      logic [SIZE-1:0] item;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rx_logic_if #(.SIZE(SIZE), .PORT_COUNT(PORT_COUNT)) bus ();

   rx_logic #(
      .ID(0),
      .SIZE(SIZE),
      .PORT_COUNT(PORT_COUNT),
      .PTR_BITS(PTR_BITS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.master)
   );

   int n_checks = 0;
   int n_fail   = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [PORT_COUNT-1:0] prev_ack;
   bit gap_en    = 1'b0;
   bit have_last = 1'b0;
   int cyc       = 0;
   int last_cyc  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int unsigned port, input logic [SIZE-1:0] item);
      exp_t e;
      bus.fifo_push_data[port*SIZE +: SIZE] = item;
      bus.fifo_push_req[port] = ~bus.fifo_push_req[port];
      e.port = port;
      e.item = item;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check_eq("drain", sb.size(), 0);
      step();
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset === 1'b0 && bus.fifo_write === 1'b1) begin
         check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check_eq($sformatf("item_p%0d", mon_e.port), 32'(bus.fifo_item_in), 32'(mon_e.item));
            check_eq($sformatf("ack_toggle_p%0d", mon_e.port),
                     32'(bus.fifo_push_ack ^ prev_ack), 32'(1) << mon_e.port);
         end
         if (gap_en) begin
            if (have_last) check_eq("write_gap", cyc - last_cyc, 2);
            have_last = 1'b1;
            last_cyc  = cyc;
         end
      end
      prev_ack = bus.fifo_push_ack;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [PORT_COUNT-1:0] saved_ack;
      int lat;

      // Reset with junk on req
      reset              = 1'b1;
      bus.fifo_full      = 1'b0;
      bus.fifo_push_req  = PORT_COUNT'($urandom);
      bus.fifo_push_data = '0;
      step();
      check_eq("rst_write", 32'(bus.fifo_write), 0);
      check_eq("rst_ack", 32'(bus.fifo_push_ack), 0);
      check_eq("rst_item", 32'(bus.fifo_item_in), 0);
      bus.fifo_push_req = PORT_COUNT'($urandom);
      step();
      bus.fifo_push_req = '0;
      reset             = 1'b0;

      // Single item with latency
      push(2, 8'hA5);
      lat = 0;
      for (int c = 1; c <= LAT + 4 && lat == 0; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.fifo_write === 1'b1) begin
            lat = c;
            check_eq("t2_item", 32'(bus.fifo_item_in), 32'h0A5);
            check_eq("t2_ack2", 32'(bus.fifo_push_ack[2]), 1);
         end
      end
      check_eq("t2_latency", lat, LAT);
      @(negedge clk);
      check_eq("t2_write_drop", 32'(bus.fifo_write), 0);
      wait_drain(20);

      // Round-robin: serve port 4 so the pointer sits at 0, then all five pending
      push(4, 8'h44);
      wait_drain(20);
      gap_en    = 1'b1;
      have_last = 1'b0;
      for (int k = 0; k < PORT_COUNT; k++) push(k, 8'h10 + 8'(k));
      wait_drain(40);
      gap_en = 1'b0;
      push(0, 8'h60);
      push(3, 8'h63);
      wait_drain(20);

      // Fifo full: pointer moved to 1 first so port 1 leads port 4
      push(0, 8'h70);
      wait_drain(20);
      bus.fifo_full = 1'b1;
      push(1, 8'h81);
      push(4, 8'h84);
      saved_ack = bus.fifo_push_ack;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_eq("t4_no_write", 32'(bus.fifo_write), 0);
         check_eq("t4_ack_hold", 32'(bus.fifo_push_ack), 32'(saved_ack));
      end
      bus.fifo_full = 1'b0;
      wait_drain(20);

      // Wrap: pointer to 4, then 4 and 0 pending
      push(3, 8'h93);
      wait_drain(20);
      push(4, 8'hA4);
      push(0, 8'hB0);
      wait_drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
